// File: rtl/mem_responder.sv
// mem_responder: latency-configurable word memory answering a held read/write request with a one-cycle ready pulse; define MEM_MISALIGN_TRAP_EN to flag and suppress misaligned accesses via err
module mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ready,
  output logic                  busy,
  output logic                  err
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t                  r_state, w_next;
  logic [3:0]              r_count;
  logic [DEPTH_LOG2-1:0]   r_idx;
  logic [DATA_WIDTH-1:0]   r_wdata, r_rdata;
  logic                    r_op_wr, r_mis, r_ready, r_err;
  logic                    w_req, w_commit, w_mis_in, w_unused;
  logic [DATA_WIDTH-1:0]   r_mem [0:(1<<DEPTH_LOG2)-1];
  assign w_req    = mem_read | mem_write;
  assign w_commit = (r_state == WAIT) && (r_count == 4'd0);
`ifdef MEM_MISALIGN_TRAP_EN
  assign w_mis_in = |addr[1:0];
`else
  assign w_mis_in = 1'b0;
`endif
  assign w_unused = ^{addr[ADDR_WIDTH-1:DEPTH_LOG2+2], addr[1:0]};
  assign rdata = r_rdata;
  assign ready = r_ready;
  assign err   = r_err;
  assign busy  = r_state != IDLE;
  // next-state: accept in IDLE, count down in WAIT, DONE always returns to IDLE
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (w_req ? WAIT : IDLE) :
             r_state == WAIT ? (r_count == 4'd0 ? DONE : WAIT) : IDLE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  // request latch, latency counter, registered read data and completion flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 4'd0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= w_commit;
      r_err   <= w_commit & r_mis;
      if (r_state == IDLE && w_req) begin
        r_idx   <= addr[DEPTH_LOG2+1:2];
        r_wdata <= wdata;
        r_op_wr <= mem_write;
        r_mis   <= w_mis_in;
        r_count <= 4'(LATENCY - 1);
      end else if (r_state == WAIT && r_count != 4'd0) begin
        r_count <= r_count - 4'd1;
      end
      if (w_commit && !r_op_wr && !r_mis) r_rdata <= r_mem[r_idx];
    end
  end
  // array write at commit; reset on the same edge aborts it
  always_ff @(posedge clk) begin
    if (!reset && w_commit && r_op_wr && !r_mis) r_mem[r_idx] <= r_wdata;
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of latency, ready/busy timing, write priority, wrap, reset abort and misalignment
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        reset, mem_read, mem_write, ready, busy, err;
  logic [31:0] addr, wdata, rdata;
  int          total = 0, bad = 0, lat;
  mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(8), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready(input string tag, output int n);
    n = 0;
    do begin
      step();
      n++;
      if (!ready) chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    end while (!ready && n < 20);
    chk({tag, "_lat"}, n, 32'd3);
  endtask
  task automatic txn(input string tag, input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    mem_read = rd; mem_write = wr; addr = a; wdata = d;
    wait_ready(tag, lat);
    chk({tag, "_busy_rdy"}, {31'd0, busy}, 32'd1);
  endtask
  task automatic drop(input string tag);
    step();
    mem_read = 1'b0; mem_write = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'hFFFF_FFFF;
    chk({tag, "_ready_off"}, {31'd0, ready}, 32'd0);
    chk({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
  endtask
  initial begin
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    step(); step();
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    step();
    txn("t1_wr", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    chk("t1_wr_err", {31'd0, err}, 32'd0);
    drop("t1_wr");
    txn("t1_rd", 1'b1, 1'b0, 32'h10, 32'h0);
    chk("t1_rd_data", rdata, 32'hDEAD_BEEF);
    drop("t1_rd");
    txn("t2_both", 1'b1, 1'b1, 32'h20, 32'h1234);
    chk("t2_rdata_kept", rdata, 32'hDEAD_BEEF);
    drop("t2_both");
    txn("t2_rd", 1'b1, 1'b0, 32'h20, 32'h0);
    chk("t2_rd_data", rdata, 32'h1234);
    drop("t2_rd");
    txn("t3_wr", 1'b0, 1'b1, 32'h400, 32'h55);
    drop("t3_wr");
    txn("t3_rd", 1'b1, 1'b0, 32'h000, 32'h0);
    chk("t3_wrap", rdata, 32'h55);
    drop("t3_rd");
    txn("t4_pre", 1'b0, 1'b1, 32'h20, 32'h1111);
    drop("t4_pre");
    mem_write = 1'b1; addr = 32'h20; wdata = 32'h2222;
    step();
    chk("t4_wait_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1; mem_write = 1'b0;
    step();
    reset = 1'b0;
    chk("t4_ready", {31'd0, ready}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_err", {31'd0, err}, 32'd0);
    chk("t4_rdata", rdata, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_no_ready", {31'd0, ready}, 32'd0);
    end
    txn("t4_rd", 1'b1, 1'b0, 32'h20, 32'h0);
    chk("t4_rd_data", rdata, 32'h1111);
    drop("t4_rd");
    txn("t5_a", 1'b1, 1'b0, 32'h10, 32'h0);
    step();
    chk("t5_pulse_w", {31'd0, ready}, 32'd0);
    wait_ready("t5_b", lat);
    chk("t5_rd_data", rdata, 32'hDEAD_BEEF);
    drop("t5_b");
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_no_second", {30'd0, ready, busy}, 32'd0);
    end
    txn("t6_wr", 1'b0, 1'b1, 32'h13, 32'hAA);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("t6_err", {31'd0, err}, 32'd1);
`else
    chk("t6_err", {31'd0, err}, 32'd0);
`endif
    drop("t6_wr");
    chk("t6_err_clr", {31'd0, err}, 32'd0);
    txn("t6_rd", 1'b1, 1'b0, 32'h10, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("t6_word", rdata, 32'hDEAD_BEEF);
`else
    chk("t6_word", rdata, 32'hAA);
`endif
    drop("t6_rd");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
